core_s1: RTL
============

Name: core_s1

Overview:
- Stage 1 (fetch) of the LETC core.
- Holds the PC and issues one instruction fetch at a time to the MMU/icache port (mmu_instr_req_s / mmu_instr_rsp_s).
- Registers the returned word into an output holding flop, presented to s2 as s1_to_s2_s.
- Accepts redirects from s2 (s2_to_s1_s) and stalls when s2 stalls.

Parameters:
- RESET_PC, core_pkg::RESET_PC (32'h00000000): first fetch address after reset.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- o_mmu_instr_req  out  mmu_instr_req_s  fetch request {addr, valid}.
- i_mmu_instr_rsp  in  mmu_instr_rsp_s  fetch response {instr, ready, illegal}.
- o_s1_to_s2  out  s1_to_s2_s  {valid, pc, instr} to s2.
- i_s2_to_s1  in  s2_to_s1_s  {branch_en, branch_target_addr} redirect from s2.
- i_s2_stall  in  1  s2 cannot accept o_s1_to_s2 this cycle.
- o_s1_fetch_fault  out  1  qualifies o_s1_to_s2; the word came back with illegal=1.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - pc=RESET_PC; state=FETCH.
  - o_s1_to_s2.valid=0, .pc=0, .instr=0; o_s1_fetch_fault=0.
  - o_mmu_instr_req.valid=0 while in reset; addr=RESET_PC.
- MMU handshake:
  - req.valid is driven from state and is never registered off a response.
  - Once valid=1, valid and addr are held stable until the cycle rsp.ready=1. At most one request is outstanding.
  - rsp.instr/illegal are sampled only when ready=1.
- Output flop:
  - Loaded on ready. Holds {valid, pc, instr, fault} while i_s2_stall=1.
  - Cleared to valid=0 when s2 consumes it (valid & ~stall) and no new word arrives that cycle.
- States:
  - FETCH:
    - req.valid = ~(o_s1_to_s2.valid & i_s2_stall); req.addr = pc.
    - On ready & ~illegal: output<={1,pc,instr,0}; pc<=pc+32'd4 (wraps mod 2^32); stay in FETCH.
    - On ready & illegal: output<={1,pc,instr,1}; go to FAULT.
  - KILL:
    - req.valid=1; addr = killed address (held).
    - On ready: discard the response, never load the output; go to FETCH.
  - FAULT:
    - req.valid=0; output held until consumed, then cleared.
    - Stays in FAULT until branch_en.
- Redirect (i_s2_to_s1.branch_en=1) has highest priority over every other event:
  - pc<=branch_target_addr with bits [1:0] forced to 0.
  - Output valid<=0 next cycle, regardless of stall.
  - If a request is in flight and ready=0 this cycle: go to KILL (killed addr kept in a separate flop); otherwise go to FETCH.
  - branch_en in the same cycle as ready: the response is discarded and the output is not loaded.
  - branch_en while in KILL: update pc, stay in KILL.
  - branch_en while in FAULT: go to FETCH.
- Timing:
  - Latency: req issued cycle N, ready at N+k (k≥0), output valid at N+k+1. With k=0, a zero-wait cache gives 1 instruction per cycle.
  - Next request is presented in the cycle after ready, from the updated pc.
- Stall: while output valid & i_s2_stall, no new request is started. A request already in flight still completes into the flop only if the flop is free. Guarantee by construction: a request is issued only when the flop will be free.
- Reset mid-request: all state is dropped. The MMU must tolerate valid falling without ready.

Optional Feature:
- Macro: LETC_CORE_S1_PERF_CNT_EN.
- Defined: adds port o_s1_fetch_count (out, 64 bits).
  - Increments by 1 on each cycle where the output flop is loaded (non-killed ready).
  - Resets to 0; wraps mod 2^64.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- core_pkg gains s1_state_e {S1_FETCH, S1_KILL, S1_FAULT} (logic [1:0]) and constant INSTR_BYTES = 4.
- Existing s1_to_s2_s, s2_to_s1_s, mmu_instr_req_s and mmu_instr_rsp_s are reused unchanged.
- One natural sub-module: core_s1_pc (PC register, +4 incrementer, redirect mux, killed-address flop). The FSM and output flop stay in core_s1.

Test Plan:
- Reset release, cache ready same cycle as valid (k=0):
  - req.addr = 0x0, 0x4, 0x8 on consecutive cycles.
  - o_s1_to_s2 = {1,0x0,instrA}, {1,0x4,instrB}, … one cycle later.
- k=3 wait states:
  - req.valid stays high and addr=0x0 stable for 4 cycles.
  - Output valid one cycle after ready; the next req for 0x4 appears that cycle.
- i_s2_stall=1 for 5 cycles with the output valid at pc=0x8:
  - output holds {1,0x8,instr}; req.valid=0 throughout.
  - After stall drops, req for 0xC is issued.
- branch_en target=0x1003 while req 0x10 is waiting (ready=0):
  - enters KILL; the response for 0x10 is dropped and never appears at s2.
  - Next req.addr=0x1000; output shows pc=0x1000.
- rsp illegal=1 at pc=0x20:
  - output {1,0x20,x}, fault=1; no further requests.
  - branch_en target=0x100 resumes with req 0x100, fault=0.
- pc=0xFFFFFFFC fetch completes → next req.addr=0x00000000. With LETC_CORE_S1_PERF_CNT_EN defined, the counter equals the number of delivered words (killed responses excluded).

Source files
------------

// File: rtl/core_pkg.sv
// Shared LETC core types: MMU fetch port, inter-stage structs and the s1 fetch state encoding.
package core_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S1_FETCH,
        S1_KILL,
        S1_FAULT
    } s1_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        valid;
    } mmu_instr_req_s;

    typedef struct packed {
        logic [31:0] instr;
        logic        ready;
        logic        illegal;
    } mmu_instr_rsp_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } s1_to_s2_s;

    typedef struct packed {
        logic        branch_en;
        logic [31:0] branch_target_addr;
    } s2_to_s1_s;

endpackage

// File: rtl/core_s1_pc.sv
// s1 program counter: PC register with +4 advance, redirect mux and the held address of a killed fetch.
module core_s1_pc
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        advance,
    input  logic        capture_kill,
    output logic [31:0] pc,
    output logic [31:0] killed_addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            killed_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                pc <= {redirect_addr[31:2], 2'b00};
            end else if (advance) begin
                pc <= pc + 32'(INSTR_BYTES);
            end
            // The abandoned request must keep its address until the MMU answers it.
            if (capture_kill) begin
                killed_addr <= pc;
            end
        end
    end

endmodule

// File: rtl/core_s1.sv
// LETC core stage 1 (fetch): one outstanding MMU fetch, output holding flop to s2, redirect handling.
// Optional fetch counter port o_s1_fetch_count is built when LETC_CORE_S1_PERF_CNT_EN is defined.
//
// state    | meaning
// S1_FETCH | normal fetching from pc; request only when the output flop will be free
// S1_KILL  | a redirected request is still in flight; its response is discarded
// S1_FAULT | an illegal fetch was delivered; idle until s2 redirects
module core_s1
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    output mmu_instr_req_s o_mmu_instr_req,
    input  mmu_instr_rsp_s i_mmu_instr_rsp,
    output s1_to_s2_s      o_s1_to_s2,
    input  s2_to_s1_s      i_s2_to_s1,
    input  logic           i_s2_stall,
    output logic           o_s1_fetch_fault
`ifdef LETC_CORE_S1_PERF_CNT_EN
    ,
    output logic [63:0]    o_s1_fetch_count
`endif
);

    s1_state_e   state;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic [31:0] pc;
    logic [31:0] killed_addr;
    logic        branch;
    logic        req_valid;
    logic        accept;
    logic        load_out;
    logic        advance;
    logic        capture_kill;

    always_comb begin
        branch = i_s2_to_s1.branch_en;
        unique case (state)
            S1_FETCH: req_valid = ~(out_valid & i_s2_stall);
            S1_KILL:  req_valid = 1'b1;
            default:  req_valid = 1'b0;
        endcase
        // Drop the request while reset is held so the MMU never sees a stale fetch.
        req_valid    = req_valid & i_rst_n;
        accept       = req_valid & i_mmu_instr_rsp.ready;
        load_out     = accept & (state == S1_FETCH) & ~branch;
        advance      = load_out & ~i_mmu_instr_rsp.illegal;
        capture_kill = branch & (state == S1_FETCH) & req_valid & ~i_mmu_instr_rsp.ready;
    end

    core_s1_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .redirect      (branch),
        .redirect_addr (i_s2_to_s1.branch_target_addr),
        .advance       (advance),
        .capture_kill  (capture_kill),
        .pc            (pc),
        .killed_addr   (killed_addr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S1_FETCH;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            out_fault <= 1'b0;
        end else if (branch) begin
            out_valid <= 1'b0;
            out_fault <= 1'b0;
            unique case (state)
                S1_KILL:  state <= accept ? S1_FETCH : S1_KILL;
                S1_FETCH: state <= capture_kill ? S1_KILL : S1_FETCH;
                default:  state <= S1_FETCH;
            endcase
        end else begin
            if (load_out) begin
                out_valid <= 1'b1;
                out_pc    <= pc;
                out_instr <= i_mmu_instr_rsp.instr;
                out_fault <= i_mmu_instr_rsp.illegal;
                if (i_mmu_instr_rsp.illegal) begin
                    state <= S1_FAULT;
                end
            end else if (out_valid & ~i_s2_stall) begin
                out_valid <= 1'b0;
                out_fault <= 1'b0;
            end
            if ((state == S1_KILL) && accept) begin
                state <= S1_FETCH;
            end
        end
    end

    assign o_mmu_instr_req.valid = req_valid;
    assign o_mmu_instr_req.addr  = (state == S1_KILL) ? killed_addr : pc;
    assign o_s1_to_s2.valid      = out_valid;
    assign o_s1_to_s2.pc         = out_pc;
    assign o_s1_to_s2.instr      = out_instr;
    assign o_s1_fetch_fault      = out_fault;

`ifdef LETC_CORE_S1_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_s1_fetch_count <= '0;
        end else if (load_out) begin
            o_s1_fetch_count <= o_s1_fetch_count + 64'd1;
        end
    end
`endif

endmodule
